// File: rtl/corner_extractor.sv
// Extracts the top/bottom/left/right extreme points of a binary mask per video frame.
// Optional CORNER_EXTRACTOR_MIN_COUNT_EN: frames with fewer than p_min_pixels set pixels publish as empty.
module corner_extractor #(
  parameter int unsigned p_bit_width_in = 11,
  parameter int unsigned p_width        = 640,
  parameter int unsigned p_height       = 480,
  parameter int unsigned p_min_pixels   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          VGA_BLANK_N,
  input  logic                          VGA_VS,
  input  logic                          data_in,
  output logic [8*p_bit_width_in-1:0]   data_out,
  output logic                          frame_valid,
  output logic                          frame_empty
);

  localparam int unsigned cnt_w = (p_bit_width_in > 16) ? p_bit_width_in : 16;
  localparam int unsigned cw    = p_bit_width_in;

  // Raster counters must be able to hold the active extent without saturating into it.
  if ((p_width >= (2 ** cnt_w)) || (p_height >= (2 ** cnt_w)) || (p_min_pixels >= (2 ** cnt_w))) begin : g_cfg_check
    $error("corner_extractor: parameter exceeds counter range");
  end

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACCUM     = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_clear;
  logic             w_publish;
  logic             w_accum;

  logic [cnt_w-1:0] r_x;
  logic [cnt_w-1:0] r_y;
  logic             r_blank_prev;
  logic             r_vs_prev;

  logic             w_vs_fall;
  logic             w_blank_fall;
  logic             w_qual;
  logic [cw-1:0]    w_px_x;
  logic [cw-1:0]    w_px_y;

  logic             r_found;
  logic             w_found_pub;
  logic [cw-1:0]    r_top_x;
  logic [cw-1:0]    r_top_y;
  logic [cw-1:0]    r_bot_x;
  logic [cw-1:0]    r_bot_y;
  logic [cw-1:0]    r_left_x;
  logic [cw-1:0]    r_left_y;
  logic [cw-1:0]    r_right_x;
  logic [cw-1:0]    r_right_y;

  assign w_vs_fall    = r_vs_prev & ~VGA_VS;
  assign w_blank_fall = r_blank_prev & ~VGA_BLANK_N;
  assign w_qual       = VGA_BLANK_N & data_in &
                        (r_x < cnt_w'(p_width)) & (r_y < cnt_w'(p_height));
  assign w_px_x       = cw'(r_x);
  assign w_px_y       = cw'(r_y);

  // Edge-detect history for sync and blanking.
  always_ff @(posedge clk or posedge reset) begin : p_sync_hist
    if (reset) begin
      r_vs_prev    <= 1'b0;
      r_blank_prev <= 1'b0;
    end else begin
      r_vs_prev    <= VGA_VS;
      r_blank_prev <= VGA_BLANK_N;
    end
  end

  // Pixel column counter: runs during active video, saturates on a missing blank.
  always_ff @(posedge clk or posedge reset) begin : p_x_cnt
    if (reset) begin
      r_x <= '0;
    end else if (!VGA_BLANK_N) begin
      r_x <= '0;
    end else if (r_x != '1) begin
      r_x <= r_x + cnt_w'(1);
    end
  end

  // Line counter: advances at the end of each active line, restarts on frame sync.
  always_ff @(posedge clk or posedge reset) begin : p_y_cnt
    if (reset) begin
      r_y <= '0;
    end else if (w_vs_fall) begin
      r_y <= '0;
    end else if (w_blank_fall && (r_y != '1)) begin
      r_y <= r_y + cnt_w'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin : p_state
    if (reset) begin
      r_state <= WAIT_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame sync wins over a coincident pixel so the next frame always starts clean.
  always_comb begin : p_next
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_publish    = 1'b0;
    w_accum      = 1'b0;
    case (r_state)
      WAIT_SYNC: begin
        if (w_vs_fall) begin
          w_clear      = 1'b1;
          w_state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (w_vs_fall) begin
          w_clear   = 1'b1;
          w_publish = 1'b1;
        end else if (w_qual) begin
          w_accum = 1'b1;
        end
      end
      default: begin
        w_state_next = WAIT_SYNC;
      end
    endcase
  end

  // Extreme-point accumulators; ties on left/right keep the earlier pixel.
  always_ff @(posedge clk or posedge reset) begin : p_accum
    if (reset) begin
      r_found   <= 1'b0;
      r_top_x   <= '0;
      r_top_y   <= '0;
      r_bot_x   <= '0;
      r_bot_y   <= '0;
      r_left_x  <= '0;
      r_left_y  <= '0;
      r_right_x <= '0;
      r_right_y <= '0;
    end else if (w_clear) begin
      r_found   <= 1'b0;
      r_top_x   <= '0;
      r_top_y   <= '0;
      r_bot_x   <= '0;
      r_bot_y   <= '0;
      r_left_x  <= '0;
      r_left_y  <= '0;
      r_right_x <= '0;
      r_right_y <= '0;
    end else if (w_accum) begin
      r_bot_x <= w_px_x;
      r_bot_y <= w_px_y;
      if (!r_found) begin
        r_found   <= 1'b1;
        r_top_x   <= w_px_x;
        r_top_y   <= w_px_y;
        r_left_x  <= w_px_x;
        r_left_y  <= w_px_y;
        r_right_x <= w_px_x;
        r_right_y <= w_px_y;
      end else begin
        if (w_px_x < r_left_x) begin
          r_left_x <= w_px_x;
          r_left_y <= w_px_y;
        end
        if (w_px_x > r_right_x) begin
          r_right_x <= w_px_x;
          r_right_y <= w_px_y;
        end
      end
    end
  end

`ifdef CORNER_EXTRACTOR_MIN_COUNT_EN
  localparam int unsigned mc_w = (p_min_pixels < 1) ? 1 : $clog2(p_min_pixels + 1);

  logic [mc_w-1:0] r_count;

  // Set-pixel count per frame, saturating at the threshold.
  always_ff @(posedge clk or posedge reset) begin : p_count
    if (reset) begin
      r_count <= '0;
    end else if (w_clear) begin
      r_count <= '0;
    end else if (w_accum && (r_count < mc_w'(p_min_pixels))) begin
      r_count <= r_count + mc_w'(1);
    end
  end

  assign w_found_pub = r_found && (r_count >= mc_w'(p_min_pixels));
`else
  assign w_found_pub = r_found;
`endif

  // Published result; an empty frame keeps the last good coordinates.
  always_ff @(posedge clk or posedge reset) begin : p_out
    if (reset) begin
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_empty <= 1'b1;
    end else begin
      frame_valid <= w_publish;
      if (w_publish) begin
        if (w_found_pub) begin
          data_out    <= {r_right_y, r_right_x, r_left_y, r_left_x,
                          r_bot_y, r_bot_x, r_top_y, r_top_x};
          frame_empty <= 1'b0;
        end else begin
          frame_empty <= 1'b1;
        end
      end
    end
  end

endmodule
